// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline hazard controller: load-use/branch stalls, flush, dmem freeze
// Optional saturating performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int REG_AW       = 5,
  parameter int LOAD_STALL   = 1,
  parameter int BRANCH_IN_ID = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              if_id_branch,
  input  logic              branch_taken,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic              id_ex_reg_write,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              ex_mem_mem_read,
  input  logic [REG_AW-1:0] ex_mem_rt,
  input  logic              ex_mem_mem_access,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  freeze_cycles
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_LSTALL = 1'b1;
  localparam logic [2:0] INIT_CNT = 3'(LOAD_STALL - 1);
  localparam logic       MULTI    = (LOAD_STALL > 1);
  localparam logic       BR_EN    = (BRANCH_IN_ID != 0);

  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic m_load_ex, m_alu_ex, m_load_mem;
  logic lu, bh, fz, stall;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  assign m_load_ex  = (id_ex_rt != '0) &&
                      (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
  assign m_alu_ex   = (id_ex_rd != '0) &&
                      (id_ex_rd == if_id_rs || (if_id_uses_rt && id_ex_rd == if_id_rt));
  assign m_load_mem = (ex_mem_rt != '0) &&
                      (ex_mem_rt == if_id_rs || (if_id_uses_rt && ex_mem_rt == if_id_rt));

  assign lu = id_ex_mem_read && m_load_ex;
  assign bh = BR_EN && if_id_branch &&
              ((id_ex_reg_write && m_alu_ex) || (ex_mem_mem_read && m_load_mem));
  assign fz = ex_mem_mem_access && !dmem_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (fz) begin
      stall = 1'b0;
    end else if (state_q == S_LSTALL) begin
      stall = 1'b1;
      cnt_d = cnt_q - 3'd1;
      if (cnt_q <= 3'd1) state_d = S_RUN;
    end else if (lu || bh) begin
      stall = 1'b1;
      if (lu && MULTI) begin
        state_d = S_LSTALL;
        cnt_d   = INIT_CNT;
      end
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst_n) begin
      pc_write = 1'b0;
    end else if (fz) begin
      pipe_freeze = 1'b1;
    end else if (stall) begin
      id_ex_bubble = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = branch_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q, flush_q, freeze_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (id_ex_bubble && stall_q != '1) stall_q <= stall_q + CNT_ONE;
      if (if_id_flush && flush_q != '1) flush_q <= flush_q + CNT_ONE;
      if (pipe_freeze && freeze_q != '1) freeze_q <= freeze_q + CNT_ONE;
    end
  end

  assign stall_cycles  = stall_q;
  assign flush_count   = flush_q;
  assign freeze_cycles = freeze_q;
`else
  assign stall_cycles  = '0;
  assign flush_count   = '0;
  assign freeze_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit over three parameter sets
module tb_hazard_ctrl_unit;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [15:0] zc;
  } exp_t;

  localparam int LSA [3] = '{1, 3, 7};
  localparam int BIA [3] = '{1, 1, 0};
  localparam int CWA [3] = '{16, 4, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] rs, rt, idrt, rd, emrt;
  logic       urt, br, tk, mr, rw, emr, acc, rdy;

  logic [4:0]  ctl [3];
  logic [15:0] sc [3], fc [3], zc [3];
  logic [15:0] sc0_w, fc0_w, zc0_w;
  logic [3:0]  sc1_w, fc1_w, zc1_w;
  logic [2:0]  sc2_w, fc2_w, zc2_w;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(1), .BRANCH_IN_ID(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(urt),
    .if_id_branch(br), .branch_taken(tk), .id_ex_mem_read(mr), .id_ex_rt(idrt),
    .id_ex_reg_write(rw), .id_ex_rd(rd), .ex_mem_mem_read(emr), .ex_mem_rt(emrt),
    .ex_mem_mem_access(acc), .dmem_ready(rdy),
    .pc_write(ctl[0][4]), .if_id_write(ctl[0][3]), .id_ex_bubble(ctl[0][2]),
    .if_id_flush(ctl[0][1]), .pipe_freeze(ctl[0][0]),
    .stall_cycles(sc0_w), .flush_count(fc0_w), .freeze_cycles(zc0_w));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(3), .BRANCH_IN_ID(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(urt),
    .if_id_branch(br), .branch_taken(tk), .id_ex_mem_read(mr), .id_ex_rt(idrt),
    .id_ex_reg_write(rw), .id_ex_rd(rd), .ex_mem_mem_read(emr), .ex_mem_rt(emrt),
    .ex_mem_mem_access(acc), .dmem_ready(rdy),
    .pc_write(ctl[1][4]), .if_id_write(ctl[1][3]), .id_ex_bubble(ctl[1][2]),
    .if_id_flush(ctl[1][1]), .pipe_freeze(ctl[1][0]),
    .stall_cycles(sc1_w), .flush_count(fc1_w), .freeze_cycles(zc1_w));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(7), .BRANCH_IN_ID(0), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(urt),
    .if_id_branch(br), .branch_taken(tk), .id_ex_mem_read(mr), .id_ex_rt(idrt),
    .id_ex_reg_write(rw), .id_ex_rd(rd), .ex_mem_mem_read(emr), .ex_mem_rt(emrt),
    .ex_mem_mem_access(acc), .dmem_ready(rdy),
    .pc_write(ctl[2][4]), .if_id_write(ctl[2][3]), .id_ex_bubble(ctl[2][2]),
    .if_id_flush(ctl[2][1]), .pipe_freeze(ctl[2][0]),
    .stall_cycles(sc2_w), .flush_count(fc2_w), .freeze_cycles(zc2_w));

  assign sc[0] = sc0_w;        assign fc[0] = fc0_w;        assign zc[0] = zc0_w;
  assign sc[1] = 16'(sc1_w);   assign fc[1] = 16'(fc1_w);   assign zc[1] = 16'(zc1_w);
  assign sc[2] = 16'(sc2_w);   assign fc[2] = 16'(fc2_w);   assign zc[2] = 16'(zc2_w);

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: bubbles still owed after the current cycle, plus event tallies.
  int pend [3];
  int n_st [3], n_fl [3], n_fz [3];

  function automatic bit dep(input logic [4:0] r);
    return (r != 0) && (r == rs || (urt && r == rt));
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic step();
    exp_t e;
    bit   lu, bh, fz;
    for (int i = 0; i < 3; i++) begin
      e = '0;
      lu = mr && dep(idrt);
      bh = (BIA[i] != 0) && br && ((rw && dep(rd)) || (emr && dep(emrt)));
      fz = acc && !rdy;
      if (!rst_n) begin
        pend[i] = 0; n_st[i] = 0; n_fl[i] = 0; n_fz[i] = 0;
        e.ctl = 5'b00000;
      end else begin
`ifdef HAZARD_PERF_CNT_EN
        e.sc = 16'(sat(n_st[i], CWA[i]));
        e.fc = 16'(sat(n_fl[i], CWA[i]));
        e.zc = 16'(sat(n_fz[i], CWA[i]));
`endif
        if (fz) begin
          e.ctl = 5'b00001;
          n_fz[i]++;
        end else if (pend[i] > 0) begin
          e.ctl = 5'b00100;
          pend[i]--;
          n_st[i]++;
        end else if (lu || bh) begin
          e.ctl = 5'b00100;
          if (lu) pend[i] = LSA[i] - 1;
          n_st[i]++;
        end else if (tk) begin
          e.ctl = 5'b11010;
          n_fl[i]++;
        end else begin
          e.ctl = 5'b11000;
        end
      end
      case (i)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs = 0; rt = 0; idrt = 0; rd = 0; emrt = 0;
    urt = 0; br = 0; tk = 0; mr = 0; rw = 0; emr = 0; acc = 0; rdy = 1;
  endtask

  task automatic cmp(input int i, input exp_t e);
    checks++;
    if (ctl[i] !== e.ctl) begin
      failures++;
      $display("FAIL ctl dut%0d t=%0t got=%b exp=%b", i, $time, ctl[i], e.ctl);
    end
    checks++;
    if (sc[i] !== e.sc || fc[i] !== e.fc || zc[i] !== e.zc) begin
      failures++;
      $display("FAIL counters dut%0d t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d",
               i, $time, sc[i], fc[i], zc[i], e.sc, e.fc, e.zc);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) cmp(0, q0.pop_front());
    if (q1.size() > 0) cmp(1, q1.pop_front());
    if (q2.size() > 0) cmp(2, q2.pop_front());
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0; n_st[i] = 0; n_fl[i] = 0; n_fz[i] = 0;
    end
    clr();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // single load-use hazard, then idle long enough to drain the longest stall
    mr = 1; idrt = 8; rs = 8;
    step();
    clr();
    repeat (8) step();

    // zero-register and rt-as-destination exclusions
    mr = 1; idrt = 0; rs = 0;
    step();
    clr();
    mr = 1; idrt = 8; rt = 8; rs = 1; urt = 0;
    step();
    clr();
    step();

    // branch operand hazard suppresses flush, flush follows once it clears
    br = 1; rw = 1; rd = 9; rt = 9; urt = 1; tk = 1;
    step();
    step();
    rw = 0;
    step();
    clr();
    step();

    // freeze held during the second bubble
    mr = 1; idrt = 8; rs = 8;
    step();
    clr();
    acc = 1; rdy = 0;
    repeat (4) step();
    clr();
    repeat (8) step();

    // reset mid-stall
    mr = 1; idrt = 8; rs = 8;
    step();
    clr();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (8) step();

    repeat (3000) begin
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      idrt = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      emrt = 5'($urandom_range(0, 3));
      urt  = 1'($urandom);
      br   = 1'($urandom);
      tk   = 1'($urandom);
      mr   = ($urandom_range(0, 3) == 0);
      rw   = 1'($urandom);
      emr  = 1'($urandom);
      acc  = 1'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    clr();
    step();

    @(negedge clk);
    #1;
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q0.size() + q1.size() + q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

- Parametrised pipeline hazard controller for the 5-stage MIPS core; successor to the single-cycle load-use stall detector.
- Sits beside the ID stage and drives PC, IF/ID, ID/EX and EX/MEM/WB pipeline control.
- Adds multi-cycle load-use stalls, branch-in-ID operand hazards, taken-branch flush, data-memory wait freeze and `$zero` exclusion.
- Optionally adds saturating performance counters.

## Interface
Parameters:
- `REG_AW`, 5: register address width.
- `LOAD_STALL`, 1: bubbles per load-use hazard; legal range 1..7.
- `BRANCH_IN_ID`, 1: 1 enables branch operand hazard detection; 0 ignores `if_id_branch`.
- `CNT_W`, 16: performance counter width.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_id_rs`, `if_id_rt` in `REG_AW`: source registers of the instruction in ID.
- `if_id_uses_rt` in 1: `rt` is a source operand, not a destination.
- `if_id_branch` in 1: the instruction in ID is a branch compared in ID.
- `branch_taken` in 1: branch in ID resolved taken.
- `id_ex_mem_read` in 1, `id_ex_rt` in `REG_AW`: load in EX and its destination.
- `id_ex_reg_write` in 1, `id_ex_rd` in `REG_AW`: ALU write in EX and its destination.
- `ex_mem_mem_read` in 1, `ex_mem_rt` in `REG_AW`: load in MEM and its destination.
- `ex_mem_mem_access` in 1: the instruction in MEM accesses data memory.
- `dmem_ready` in 1: data memory completes its access this cycle.
- `pc_write` out 1: PC may update.
- `if_id_write` out 1: IF/ID may update.
- `id_ex_bubble` out 1: zero the ID/EX control fields.
- `if_id_flush` out 1: clear IF/ID.
- `pipe_freeze` out 1: hold ID/EX, EX/MEM and MEM/WB.
- `stall_cycles`, `flush_count`, `freeze_cycles` out `CNT_W`: performance counters.

## Operation
Match terms (a destination equal to 0 never matches):
- `m(r)` = (r != 0) && (r == `if_id_rs` || (`if_id_uses_rt` && r == `if_id_rt`)).
- `lu` = `id_ex_mem_read` && `m(id_ex_rt)`.
- `bh` = `BRANCH_IN_ID` && `if_id_branch` && ((`id_ex_reg_write` && `m(id_ex_rd)`) || (`ex_mem_mem_read` && `m(ex_mem_rt)`)).
- `fz` = `ex_mem_mem_access` && !`dmem_ready`.

FSM states are RUN and LSTALL, with a 3-bit bubble counter `cnt`.
- RUN, `lu`:
  - Asserts a bubble this cycle.
  - If `LOAD_STALL` > 1, moves to LSTALL with `cnt` = `LOAD_STALL` - 1; otherwise stays in RUN.
- LSTALL:
  - Asserts a bubble unconditionally and decrements `cnt`.
  - Returns to RUN when `cnt` reaches 0.
  - Exactly `LOAD_STALL` bubbles are issued per hazard.
- Stall outputs (bubble in RUN from `lu` or `bh`, or any LSTALL cycle): `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1.
- Flush: `branch_taken` with no stall and no freeze gives `if_id_flush`=1 and `pc_write`=1. A stall suppresses the flush; the branch is re-evaluated after the stall.
- Freeze: `fz` has top priority.
  - Outputs: `pipe_freeze`=1, `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=0, `if_id_flush`=0.
  - FSM state and `cnt` hold during freeze.
- Idle (no event): `pc_write`=1, `if_id_write`=1, all other control outputs 0.

## Timing
- Control outputs are combinational from the inputs and the registered state; there is zero-cycle latency from hazard inputs to control.
- Reset (`rst_n` low, asynchronous):
  - State RUN, `cnt`=0, all counters 0.
  - While held low: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=0, `if_id_flush`=0, `pipe_freeze`=0.
- Reset asserted mid-LSTALL aborts the remaining bubbles. The first cycle after release behaves as RUN.
- `lu` and `bh` in the same cycle produce one stall. LSTALL entry follows from `lu` alone.
- `lu` and `fz` in the same cycle: freeze wins and no state change occurs. `lu` is re-evaluated next cycle.
- A new `lu` seen while in LSTALL is ignored; its ID instruction is still held, so it is re-detected in RUN.
- Counters saturate at all-ones and never wrap.

## Configuration
- Macro `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every stall cycle.
  - `flush_count` increments on every `if_id_flush` cycle.
  - `freeze_cycles` increments on every `pipe_freeze` cycle.
  - All three saturate and are cleared by `rst_n`.
- Macro undefined: the counter ports remain present and are tied to 0; no counter registers are built.

## Test plan
- `LOAD_STALL`=1, `id_ex_mem_read`=1, `id_ex_rt`=8, `if_id_rs`=8 -> one cycle with `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1; the next cycle returns to idle.
- `LOAD_STALL`=3, same hazard, inputs cleared after the first cycle -> exactly 3 consecutive bubble cycles; `stall_cycles`=3 with the macro defined.
- `id_ex_rt`=0, `if_id_rs`=0, `id_ex_mem_read`=1 -> no stall. Also `if_id_uses_rt`=0 with `if_id_rt` matching -> no stall.
- `if_id_branch`=1, `id_ex_reg_write`=1, `id_ex_rd`=9, `if_id_rt`=9, `if_id_uses_rt`=1, `branch_taken`=1 -> a stall with `if_id_flush`=0. After the hazard clears, one flush cycle occurs with `pc_write`=1.
- `LOAD_STALL`=3, `fz` held for 4 cycles during the second bubble -> 4 cycles of `pipe_freeze`=1 with `id_ex_bubble`=0, then the remaining 2 bubbles.
- `rst_n` pulsed low mid-LSTALL -> outputs are forced to reset values asynchronously; after release, no further bubbles occur and the counters read 0.
